// File: rtl/hyperram_pkg.sv
// Shared definitions for the HyperBus responder: FSM state encoding,
// command/address bit positions and register-space constants.
package hyperram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CA   = 3'd1,
        ST_LAT  = 3'd2,
        ST_WR   = 3'd3,
        ST_RD   = 3'd4
    } state_t;

    // Command/address word layout (CA[47:0], first byte on the bus is CA[47:40])
    localparam int CA_BYTES     = 6;
    localparam int CA_RW_BIT    = 47;   // 1 = read
    localparam int CA_AS_BIT    = 46;   // 1 = register space
    localparam int CA_BURST_BIT = 45;   // burst type, ignored (always linear)
    localparam int CA_ROW_HI    = 44;
    localparam int CA_ROW_LO    = 16;
    localparam int CA_COL_HI    = 2;

    // Register space
    localparam int          ID0_ADDR = 0;
    localparam int          CR0_ADDR = 8;
    localparam logic [15:0] ID0_VAL  = 16'h0C81;
    localparam logic [15:0] CR0_RST  = 16'h8F1F;

    // Word address carried by a command/address word, before truncation
    function automatic logic [31:0] ca_word_addr(input logic [47:0] ca);
        return {ca[CA_ROW_HI:CA_ROW_LO], ca[CA_COL_HI:0]};
    endfunction

endpackage

// File: rtl/hyperram_resp_mem.sv
// Backing store for the responder: single-port 2**ADDR_W x 16 synchronous
// RAM with per-byte write enables and a registered read port. Each byte lane
// is its own array so every lane has exactly one writer.
module hyperram_resp_mem #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        we,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        // Byte-lane write with enable and registered (read-before-write) read
        always_ff @(posedge clk) begin
            if (we[gi]) begin
                lane_mem[addr] <= wdata[gi*8 +: 8];
            end
            rdata[gi*8 +: 8] <= lane_mem[addr];
        end
    end

endmodule

// File: rtl/hyperram_responder.sv
// HyperBus target answering the hyper_xface controller, backed by an
// internal 16-bit memory. ck is sampled as data: every toggle is one DDR
// edge. Optional register space (ID0/CR0) is enabled by defining
// HYPERRAM_RESP_REG_EN; without it register reads return 0 and register
// writes are discarded.
module hyperram_responder
    import hyperram_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int LAT_EDGES = 22,
    parameter bit FIXED_2X  = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cs_l,
    input  logic       ck,
    input  logic       rst_l,
    input  logic [7:0] dq_in,
    output logic [7:0] dq_out,
    output logic       dq_oe,
    input  logic       rwds_in,
    output logic       rwds_out,
    output logic       rwds_oe
);

    state_t            state_reg, state_next;
    logic              ck_q;
    logic              edge_det;
    logic [7:0]        cnt_reg, cnt_next;
    logic [39:0]       ca_reg, ca_next;
    logic [47:0]       full_ca;
    logic [31:0]       ca_addr;
    logic              is_read_reg, is_read_next;
    logic              is_reg_reg, is_reg_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              lo_phase_reg, lo_phase_next;
    logic [7:0]        hold_reg, hold_next;
    logic              hi_en_reg, hi_en_next;
    logic [1:0]        wr_be_reg, wr_be_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [15:0]       wr_data_reg, wr_data_next;
    logic [7:0]        dq_out_reg, dq_out_next;
    logic              dq_oe_reg, dq_oe_next;
    logic              rwds_out_reg, rwds_out_next;
    logic              rwds_oe_reg, rwds_oe_next;
    logic              launch_hi;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic [15:0]       reg_word;
    logic [15:0]       src_word;
`ifdef HYPERRAM_RESP_REG_EN
    logic [15:0]       cr0_reg, cr0_next;
`endif

    assign edge_det = (ck != ck_q);

    // A committing write owns the RAM port for its single cycle; otherwise
    // the port continuously prefetches the current burst word.
    assign mem_addr = (wr_be_reg != 2'b00) ? wr_addr_reg : addr_reg;
    assign src_word = is_reg_reg ? reg_word : mem_rdata;

    hyperram_resp_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .addr  (mem_addr),
        .we    (wr_be_reg),
        .wdata (wr_data_reg),
        .rdata (mem_rdata)
    );

    // Register-space read mux
    always_comb begin
        reg_word = 16'h0000;
`ifdef HYPERRAM_RESP_REG_EN
        if (addr_reg == ADDR_W'(ID0_ADDR)) begin
            reg_word = ID0_VAL;
        end else if (addr_reg == ADDR_W'(CR0_ADDR)) begin
            reg_word = cr0_reg;
        end
`endif
    end

    // Next-state and output logic for the bus FSM
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        ca_next       = ca_reg;
        is_read_next  = is_read_reg;
        is_reg_next   = is_reg_reg;
        addr_next     = addr_reg;
        lo_phase_next = lo_phase_reg;
        hold_next     = hold_reg;
        hi_en_next    = hi_en_reg;
        wr_be_next    = 2'b00;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;
        dq_out_next   = dq_out_reg;
        dq_oe_next    = dq_oe_reg;
        rwds_out_next = rwds_out_reg;
        rwds_oe_next  = rwds_oe_reg;
`ifdef HYPERRAM_RESP_REG_EN
        cr0_next      = cr0_reg;
`endif
        launch_hi     = 1'b0;
        full_ca       = {ca_reg, dq_in};
        ca_addr       = ca_word_addr(full_ca);

        if (!rst_l) begin
            state_next    = ST_IDLE;
            cnt_next      = '0;
            ca_next       = '0;
            is_read_next  = 1'b0;
            is_reg_next   = 1'b0;
            addr_next     = '0;
            lo_phase_next = 1'b0;
            hold_next     = '0;
            hi_en_next    = 1'b0;
            wr_addr_next  = '0;
            wr_data_next  = '0;
            dq_out_next   = '0;
            dq_oe_next    = 1'b0;
            rwds_out_next = 1'b0;
            rwds_oe_next  = 1'b0;
`ifdef HYPERRAM_RESP_REG_EN
            cr0_next      = CR0_RST;
`endif
        end else if (cs_l) begin
            // Deselect: any edge this cycle is ignored, half words dropped
            state_next    = ST_IDLE;
            cnt_next      = '0;
            lo_phase_next = 1'b0;
            dq_out_next   = '0;
            dq_oe_next    = 1'b0;
            rwds_out_next = 1'b0;
            rwds_oe_next  = 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    state_next    = ST_CA;
                    cnt_next      = '0;
                    lo_phase_next = 1'b0;
                    rwds_oe_next  = 1'b1;
                    rwds_out_next = FIXED_2X;
                end
                ST_CA: begin
                    if (edge_det) begin
                        ca_next = full_ca[39:0];
                        if (cnt_reg == 8'(CA_BYTES - 1)) begin
                            cnt_next     = '0;
                            is_read_next = full_ca[CA_RW_BIT];
                            is_reg_next  = full_ca[CA_AS_BIT];
                            addr_next    = ca_addr[ADDR_W-1:0];
                            if (!full_ca[CA_RW_BIT] && full_ca[CA_AS_BIT]) begin
                                // Register writes carry no latency
                                state_next    = ST_WR;
                                rwds_oe_next  = 1'b0;
                                rwds_out_next = 1'b0;
                            end else begin
                                state_next = ST_LAT;
                            end
                        end else begin
                            cnt_next = cnt_reg + 8'd1;
                        end
                    end
                end
                ST_LAT: begin
                    if (edge_det) begin
                        if (cnt_reg == 8'(LAT_EDGES - 1)) begin
                            cnt_next = '0;
                            if (is_read_reg) begin
                                state_next = ST_RD;
                                launch_hi  = 1'b1;
                            end else begin
                                state_next    = ST_WR;
                                lo_phase_next = 1'b0;
                                rwds_oe_next  = 1'b0;
                                rwds_out_next = 1'b0;
                            end
                        end else begin
                            cnt_next = cnt_reg + 8'd1;
                        end
                    end
                end
                ST_WR: begin
                    if (edge_det) begin
                        if (!lo_phase_reg) begin
                            hold_next     = dq_in;
                            hi_en_next    = !rwds_in;
                            lo_phase_next = 1'b1;
                        end else begin
                            lo_phase_next = 1'b0;
                            addr_next     = addr_reg + ADDR_W'(1);
                            if (is_reg_reg) begin
`ifdef HYPERRAM_RESP_REG_EN
                                if (addr_reg == ADDR_W'(CR0_ADDR)) begin
                                    if (hi_en_reg) cr0_next[15:8] = hold_reg;
                                    if (!rwds_in)  cr0_next[7:0]  = dq_in;
                                end
`endif
                            end else begin
                                wr_be_next   = {hi_en_reg, !rwds_in};
                                wr_addr_next = addr_reg;
                                wr_data_next = {hold_reg, dq_in};
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (edge_det) begin
                        if (lo_phase_reg) begin
                            dq_out_next   = hold_reg;
                            rwds_out_next = 1'b0;
                            lo_phase_next = 1'b0;
                        end else begin
                            launch_hi = 1'b1;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase

            // Present the high byte of the current word, park the low byte
            // and move the prefetch address on to the next word.
            if (launch_hi) begin
                dq_out_next   = src_word[15:8];
                hold_next     = src_word[7:0];
                rwds_out_next = 1'b1;
                dq_oe_next    = 1'b1;
                rwds_oe_next  = 1'b1;
                lo_phase_next = 1'b1;
                addr_next     = addr_reg + ADDR_W'(1);
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            ck_q         <= 1'b0;
            cnt_reg      <= '0;
            ca_reg       <= '0;
            is_read_reg  <= 1'b0;
            is_reg_reg   <= 1'b0;
            addr_reg     <= '0;
            lo_phase_reg <= 1'b0;
            hold_reg     <= '0;
            hi_en_reg    <= 1'b0;
            wr_be_reg    <= 2'b00;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            dq_out_reg   <= '0;
            dq_oe_reg    <= 1'b0;
            rwds_out_reg <= 1'b0;
            rwds_oe_reg  <= 1'b0;
`ifdef HYPERRAM_RESP_REG_EN
            cr0_reg      <= CR0_RST;
`endif
        end else begin
            state_reg    <= state_next;
            ck_q         <= rst_l ? ck : 1'b0;
            cnt_reg      <= cnt_next;
            ca_reg       <= ca_next;
            is_read_reg  <= is_read_next;
            is_reg_reg   <= is_reg_next;
            addr_reg     <= addr_next;
            lo_phase_reg <= lo_phase_next;
            hold_reg     <= hold_next;
            hi_en_reg    <= hi_en_next;
            wr_be_reg    <= wr_be_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
            dq_out_reg   <= dq_out_next;
            dq_oe_reg    <= dq_oe_next;
            rwds_out_reg <= rwds_out_next;
            rwds_oe_reg  <= rwds_oe_next;
`ifdef HYPERRAM_RESP_REG_EN
            cr0_reg      <= cr0_next;
`endif
        end
    end

    assign dq_out   = dq_out_reg;
    assign dq_oe    = dq_oe_reg;
    assign rwds_out = rwds_out_reg;
    assign rwds_oe  = rwds_oe_reg;

endmodule

// File: doc/hyperram_responder.md
# hyperram_responder

Synthesizable HyperBus target that answers the hyper_xface controller on the same pin-level interface (dq, rwds, ck, cs_l, rst_l), backed by a small internal 16-bit memory. It is used as the device side of the link in FPGA loopback builds and in simulation benches, so the UART command path can be exercised without a physical HyperRAM. It runs on the controller's clock and treats ck as a data signal: every toggle of ck is one DDR edge.

## Interface
- ADDR_W, 10: memory depth is 2**ADDR_W 16-bit words.
- LAT_EDGES, 22: ck edges between the last CA edge and the first data edge for memory accesses and register reads.
- FIXED_2X, 1: when 1, rwds is driven high during CA to signal double latency. The latency used is always LAT_EDGES.
- clk  in  1  system clock; the same clock that generates ck.
- rstn  in  1  asynchronous active-low reset.
- cs_l  in  1  chip select, active low.
- ck  in  1  HyperBus clock from the controller.
- rst_l  in  1  device reset, active low, synchronous to clk.
- dq_in  in  8  sampled data pins.
- dq_out  out  8  driven data byte.
- dq_oe  out  1  output enable for dq.
- rwds_in  in  1  sampled rwds; acts as the write byte mask.
- rwds_out  out  1  driven rwds.
- rwds_oe  out  1  output enable for rwds.

## Operation
- Edge detect: ck_q is a registered copy of ck. An edge is any clk cycle with ck != ck_q. dq_in and rwds_in are captured on edge cycles only.
- States:
  - IDLE: waits for cs_l low, then goes to CA.
  - CA: collects 6 bytes, first byte is CA[47:40].
  - LAT: counts edges.
  - WR: receives data.
  - RD: sends data.
- CA decode:
  - CA[47]: 1 = read.
  - CA[46]: 1 = register space.
  - CA[45]: ignored; all bursts are linear.
  - Word address = {CA[44:16], CA[2:0]}, truncated to ADDR_W bits.
- After the 6th CA edge:
  - Register write: go to WR immediately.
  - All other accesses: go to LAT, then to WR or RD after LAT_EDGES edges.
- WR:
  - Bytes pair into a word, high byte first.
  - A byte with rwds_in=1 on its edge is masked and not written.
  - A completed word is written with per-byte enables, then the address increments.
- RD:
  - Responder drives dq_oe=1 and rwds_oe=1.
  - High byte goes with rwds_out=1, low byte with rwds_out=0.
  - Address increments after each low byte.
- Burst continues until cs_l rises. Address wraps from 2**ADDR_W-1 to 0.
- cs_l high in any state:
  - Return to IDLE on the next cycle.
  - dq_oe=0, rwds_oe=0.
  - A pending half word is discarded.
- rst_l low: same as cs_l high, and registers return to their reset values. Memory contents are retained.

## Timing
- Reset values: dq_out=0, dq_oe=0, rwds_out=0, rwds_oe=0, state IDLE, edge counter 0, ck_q=0.
- CA phase:
  - rwds_oe=1 on the cycle after cs_l falls.
  - rwds_out=FIXED_2X during CA and LAT.
  - rwds_oe returns to 0 entering WR.
- Read data:
  - The byte for data edge n is on dq_out the clk cycle after the edge preceding edge n. This gives one clk of setup before the controller's sampling edge.
  - The first byte is presented the cycle the LAT counter expires.
- Write commit: the memory write occurs the clk cycle after the low-byte edge.
- A simultaneous cs_l rise and edge: the edge is ignored.
- Read-after-write to the same word in consecutive transactions returns the new data. The minimum cs_l high time is one clk.

## Configuration
- HYPERRAM_RESP_REG_EN defined:
  - Register space is implemented.
  - Word 0 = ID0, read-only, 16'h0C81.
  - Word 8 = CR0, read/write, reset 16'h8F1F.
  - Other register words read 0; writes to them are ignored.
- Not defined: register reads return 16'h0000 and register writes are ignored. The zero-latency write path is still honoured.

## Structure
- Shared package hyperram_pkg holds:
  - state encoding;
  - CA bit positions;
  - ID0_VAL and CR0_RST constants.
- One sub-module, hyperram_resp_mem: single-port 2**ADDR_W x 16 synchronous RAM with 2-bit byte enable and registered read.
- All other logic (FSM, edge detect, counters) is flat in hyperram_responder.

## Test plan
- Write 32'h12345678 to word 0x10 with two words, no mask, LAT_EDGES=22, then read 2 words at 0x10 -> dq returns 12,34,56,78 and rwds toggles 1,0,1,0.
- Write 16'hAABB to word 5, then write 16'hCCDD to word 5 with the low byte masked (rwds=1) -> read of word 5 returns 16'hCCBB.
- Burst of 3 words starting at word 2**ADDR_W-1 with values 1,2,3 -> words 1023, 0 and 1 hold 1, 2 and 3 (ADDR_W=10).
- Raise cs_l after 3 CA bytes, then do a full read of word 0x10 -> no memory change, and the read returns correct data.
- Register tests:
  - With HYPERRAM_RESP_REG_EN, write CR0 = 16'h8F17 with zero latency -> reads return 16'h8F17, and reading word 0 returns 16'h0C81.
  - Without the macro, the same reads return 0.
- Assert rstn low mid-read burst -> all outputs reach their reset values immediately and the next transaction decodes normally.
